// File: rtl/frame_dump_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | frame_dump_pkg: sync bytes and FSM encoding shared by frame_dump_tx.  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
package frame_dump_pkg;

  localparam logic [7:0] SYNC0 = 8'hAA;
  localparam logic [7:0] SYNC1 = 8'h55;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] HDR0  = 3'd1;
  localparam logic [2:0] HDR1  = 3'd2;
  localparam logic [2:0] FETCH = 3'd3;
  localparam logic [2:0] LATCH = 3'd4;
  localparam logic [2:0] SEND  = 3'd5;
  localparam logic [2:0] CSUM  = 3'd6;
  localparam logic [2:0] DONE  = 3'd7;

endpackage
`default_nettype wire

// File: rtl/uart_pacer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | uart_pacer: holdoff counter and strobe interlock gating UART writes.  |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module uart_pacer #(
  parameter int HOLDOFF = 8191
) (
  input  logic clk12,
  input  logic areset_n,
  input  logic uart_busy,
  input  logic issue,
  output logic ready,
  output logic last_wr
);

  localparam int             CW      = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(HOLDOFF);

  logic [CW-1:0] cnt;
  logic          busy_q;

  always_ff @(posedge clk12 or negedge areset_n) begin
    if (!areset_n) begin
      cnt     <= CNT_MAX;
      busy_q  <= 1'b0;
      last_wr <= 1'b0;
    end else begin
      busy_q  <= uart_busy;
      last_wr <= issue;
      if (uart_busy)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
    end
  end

  // Built only from registered state so a busy edge in the issue cycle cannot cancel it.
  assign ready = !busy_q && (cnt == CNT_MAX) && !last_wr;

endmodule
`default_nettype wire

// File: rtl/frame_dump_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | frame_dump_tx: sends sync header, raster pixels and XOR checksum.     |
// | Revision 1.0                                                          |
// +-----------------------------------------------------------------------+
module frame_dump_tx
  import frame_dump_pkg::*;
#(
  parameter int WIDTH   = 40,
  parameter int HEIGHT  = 20,
  parameter int X_BITS  = 6,
  parameter int Y_BITS  = 5,
  parameter int HOLDOFF = 8191
) (
  input  logic              clk12,
  input  logic              areset_n,
  input  logic              start,
  output logic [X_BITS-1:0] read_x,
  output logic [Y_BITS-1:0] read_y,
  input  logic [7:0]        read_q,
  output logic [7:0]        uart_dat,
  output logic              uart_wr,
  input  logic              uart_busy,
  output logic              busy,
  output logic              done
);

  logic [2:0] state;
  logic [7:0] pix;
  logic [7:0] csum;
  logic [7:0] next_dat;
  logic       ready;
  logic       issue;
  logic       last_x;
  logic       last_y;

  assign last_x = (read_x == X_BITS'(WIDTH - 1));
  assign last_y = (read_y == Y_BITS'(HEIGHT - 1));

  always_comb begin
    issue    = 1'b0;
    next_dat = pix;
    case (state)
      HDR0: begin issue = ready; next_dat = SYNC0; end
      HDR1: begin issue = ready; next_dat = SYNC1; end
      SEND: begin issue = ready; next_dat = pix;   end
      CSUM: begin issue = ready; next_dat = csum;  end
      default: ;
    endcase
  end

  // The pacer's last-write flag doubles as the outgoing strobe.
  uart_pacer #(
    .HOLDOFF (HOLDOFF)
  ) u_pacer (
    .clk12     (clk12),
    .areset_n  (areset_n),
    .uart_busy (uart_busy),
    .issue     (issue),
    .ready     (ready),
    .last_wr   (uart_wr)
  );

  always_ff @(posedge clk12 or negedge areset_n) begin
    if (!areset_n) begin
      state    <= IDLE;
      read_x   <= '0;
      read_y   <= '0;
      pix      <= '0;
      csum     <= '0;
      uart_dat <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (issue)
        uart_dat <= next_dat;
      case (state)
        IDLE: if (start) begin
          state  <= HDR0;
          busy   <= 1'b1;
          read_x <= '0;
          read_y <= '0;
          csum   <= '0;
        end
        HDR0:  if (ready) state <= HDR1;
        HDR1:  if (ready) state <= FETCH;
        FETCH: state <= LATCH;
        LATCH: begin
          pix   <= read_q;
          csum  <= csum ^ read_q;
          state <= SEND;
        end
        SEND: if (ready) begin
          if (last_x && last_y) begin
            state <= CSUM;
          end else if (last_x) begin
            read_x <= '0;
            read_y <= read_y + Y_BITS'(1);
            state  <= FETCH;
          end else begin
            read_x <= read_x + X_BITS'(1);
            state  <= FETCH;
          end
        end
        CSUM: if (ready) state <= DONE;
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
